// File: rtl/proc_pkg.sv
// proc_pkg: shared FSM encoding, widths and default completion state for the processor sequencer.
package proc_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} fsm_e;
  localparam int PC_W = 3;
  localparam int STATE_W = 4;
  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;
  localparam int DEPTH = 8;
  localparam logic [STATE_W-1:0] DONE_STATE_DEF = 4'b0011;
endpackage

// File: rtl/proc_result_buf.sv
// proc_result_buf: 8x19 result register file, one write port, registered read port, clearable valid bits.
module proc_result_buf
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic [PC_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [FLAG_W-1:0] wflags,
  input  logic [PC_W-1:0]   raddr,
  output logic [DATA_W-1:0] rd_data,
  output logic [FLAG_W-1:0] rd_flags,
  output logic              rd_valid
);
  logic [DATA_W+FLAG_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DATA_W+FLAG_W-1:0] rd_q;
  logic rd_valid_q;
  always_comb begin
    valid_d = clr ? '0 : valid_q;
    if (we) valid_d[waddr] = 1'b1;
  end
  // Reads sample the pre-edge contents, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= {wdata, wflags};
    if (!rst) begin
      valid_q <= '0;
      rd_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q <= mem_q[raddr];
      rd_valid_q <= valid_q[raddr];
    end
  end
  assign {rd_data, rd_flags} = rd_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: handshake-driven pc stepping with result capture; optional watchdog via PROC_SEQ_WATCHDOG_EN.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter logic [STATE_W-1:0] DONE_STATE = DONE_STATE_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PC_W-1:0]    start_pc,
  input  logic [PC_W-1:0]    end_pc,
  output logic               run,
  output logic [PC_W-1:0]    pc,
  input  logic [STATE_W-1:0] state,
  input  logic [DATA_W-1:0]  ALU_result,
  input  logic [FLAG_W-1:0]  flags,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [3:0]         retired,
  input  logic [PC_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [FLAG_W-1:0]  rd_flags,
  output logic               rd_valid
);
  fsm_e fsm_q, fsm_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0] retired_q, retired_d;
  logic [STATE_W-1:0] prev_state_q;
  logic timeout_q, timeout_d;
  logic complete, expire, we, clr;
`ifdef PROC_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  always_comb wd_d = fsm_q == WAIT ? wd_q + 1'b1 : '0;
  always_ff @(posedge clk) wd_q <= !rst ? '0 : wd_d;
  assign expire = fsm_q == WAIT && wd_q == WD_W'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES[0];
  assign expire = 1'b0;
`endif
  // Only the rising edge into DONE_STATE counts, so a held state retires once.
  assign complete = fsm_q == WAIT && state == DONE_STATE && prev_state_q != DONE_STATE;
  always_comb begin
    fsm_d = fsm_q;
    pc_d = pc_q;
    retired_d = retired_q;
    timeout_d = 1'b0;
    we = 1'b0;
    clr = 1'b0;
    if (fsm_q == IDLE) begin
      if (start) begin
        fsm_d = ISSUE;
        pc_d = start_pc;
        retired_d = '0;
        clr = 1'b1;
      end
    end else if (abort) fsm_d = IDLE;
    else if (fsm_q == ISSUE) fsm_d = WAIT;
    else if (fsm_q == FINISH) fsm_d = IDLE;
    else if (complete) begin
      we = 1'b1;
      retired_d = retired_q + 1'b1;
      fsm_d = pc_q == end_pc ? FINISH : ISSUE;
      pc_d = pc_q == end_pc ? pc_q : pc_q + 1'b1;
    end else if (expire) begin
      fsm_d = IDLE;
      timeout_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q <= IDLE;
      pc_q <= '0;
      retired_q <= '0;
      prev_state_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      pc_q <= pc_d;
      retired_q <= retired_d;
      prev_state_q <= state;
      timeout_q <= timeout_d;
    end
  end
  proc_result_buf u_buf (
    .clk(clk), .rst(rst), .we(we), .clr(clr), .waddr(pc_q), .wdata(ALU_result), .wflags(flags),
    .raddr(rd_addr), .rd_data(rd_data), .rd_flags(rd_flags), .rd_valid(rd_valid)
  );
  assign run = fsm_q == ISSUE || fsm_q == WAIT;
  assign busy = run;
  assign done = fsm_q == FINISH;
  assign timeout = timeout_q;
  assign pc = pc_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: table-driven runs against a processor model, scoreboarded buffer readback, hand-written corner cases.
module tb_proc_sequencer;
  localparam logic [3:0] DONE = 4'b0011;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0] start_pc = '0, end_pc = '0, rd_addr = '0, flags = '0;
  logic [3:0] state = '0;
  logic [15:0] ALU_result = '0;
  logic run, busy, done, timeout, rd_valid;
  logic [2:0] pc, rd_flags;
  logic [3:0] retired;
  logic [15:0] rd_data;
  int n_chk = 0, n_fail = 0, done_cnt = 0, to_cnt = 0;

  typedef struct packed {logic [2:0] a; logic [15:0] d; logic [2:0] f;} ent_t;
  typedef struct {logic [2:0] s; logic [2:0] e; logic [2:0] hold_pc; int hold; logic [15:0] base;} vec_t;
  ent_t sb[$];
  logic [7:0] valid_exp;
  vec_t vecs[5];

  proc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .start_pc(start_pc), .end_pc(end_pc),
    .run(run), .pc(pc), .state(state), .ALU_result(ALU_result), .flags(flags), .busy(busy),
    .done(done), .timeout(timeout), .retired(retired), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_flags(rd_flags), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (timeout === 1'b1) to_cnt <= to_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Processor model: one cycle to settle into WAIT, then present DONE_STATE for `hold` cycles.
  task automatic do_instr(input logic [2:0] p, input logic [15:0] d, input logic [2:0] f,
                          input int hold, input int ret);
    tick;
    chk("pc_step", pc, p);
    chk("busy_wait", busy, 1);
    state = DONE;
    ALU_result = d;
    flags = f;
    sb.push_back({p, d, f});
    valid_exp[p] = 1'b1;
    repeat (hold) tick;
    state = 4'h0;
    ALU_result = 16'hdead;
    flags = 3'h0;
    chk("retired_step", retired, ret);
  endtask

  task automatic readback;
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.a;
      tick;
      chk("rd_data", rd_data, e.d);
      chk("rd_flags", rd_flags, e.f);
      chk("rd_valid", rd_valid, 1);
    end
    for (int a = 0; a < 8; a++) begin
      if (!valid_exp[a]) begin
        rd_addr = 3'(a);
        tick;
        chk("rd_invalid", rd_valid, 0);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, d0;
    logic [2:0] p;
    logic [15:0] d;
    n = int'(3'(v.e - v.s)) + 1;
    d0 = done_cnt;
    valid_exp = '0;
    start_pc = v.s;
    end_pc = v.e;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("issue_run", run, 1);
    chk("issue_pc", pc, v.s);
    chk("retired_clr", retired, 0);
    p = v.s;
    for (int i = 0; i < n; i++) begin
      d = v.base + 16'(16'h11 * (i + 1));
      do_instr(p, d, 3'(i), (p == v.hold_pc) ? v.hold : 1, i + 1);
      p = p + 3'd1;
    end
    chk("finish_done", done, 1);
    chk("finish_run", run, 0);
    chk("finish_busy", busy, 0);
    chk("finish_pc", pc, v.e);
    chk("finish_retired", retired, n);
    tick;
    chk("done_once", done_cnt - d0, 1);
    chk("idle_done", done, 0);
    readback;
  endtask

  initial begin
    vecs[0] = '{s: 3'd0, e: 3'd2, hold_pc: 3'd7, hold: 1, base: 16'h0000};
    vecs[1] = '{s: 3'd0, e: 3'd3, hold_pc: 3'd1, hold: 4, base: 16'h1000};
    vecs[2] = '{s: 3'd6, e: 3'd1, hold_pc: 3'd0, hold: 1, base: 16'h2000};
    vecs[3] = '{s: 3'd5, e: 3'd5, hold_pc: 3'd0, hold: 1, base: 16'h3000};
    vecs[4] = '{s: 3'd0, e: 3'd7, hold_pc: 3'd4, hold: 3, base: 16'h4000};
    rst = 1'b0;
    tick;
    tick;
    chk("rst_run", run, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_retired", retired, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", {rd_data, rd_flags}, 0);
    rst = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort coincident with completion drops the capture; start while busy is ignored.
    begin
      int d0;
      d0 = done_cnt;
      valid_exp = '0;
      start_pc = 3'd2;
      end_pc = 3'd5;
      start = 1'b1;
      tick;
      start = 1'b0;
      do_instr(3'd2, 16'h5a5a, 3'd5, 1, 1);
      start_pc = 3'd7;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("ignored_start_pc", pc, 3);
      chk("ignored_start_run", run, 1);
      state = DONE;
      ALU_result = 16'hbeef;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      state = 4'h0;
      chk("abort_run", run, 0);
      chk("abort_busy", busy, 0);
      chk("abort_retired", retired, 1);
      tick;
      chk("abort_no_done", done_cnt - d0, 0);
      readback;
    end

    // Reset in WAIT clears state and every valid bit.
    start_pc = 3'd2;
    end_pc = 3'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    do_instr(3'd2, 16'h7777, 3'd1, 1, 1);
    tick;
    rst = 1'b0;
    tick;
    chk("midrst_run", run, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_retired", retired, 0);
    rst = 1'b1;
    sb.delete();
    valid_exp = '0;
    readback;

    // Processor never completes: watchdog fires, or WAIT persists without it.
    begin
      int d0, cyc;
      d0 = done_cnt;
      start_pc = 3'd0;
      end_pc = 3'd0;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      cyc = 0;
`ifdef PROC_SEQ_WATCHDOG_EN
      while (timeout !== 1'b1 && cyc < 200) begin
        tick;
        cyc++;
      end
      chk("wd_cycles", cyc, 64);
      chk("wd_run", run, 0);
      tick;
      chk("wd_pulse_once", to_cnt, 1);
      chk("wd_no_done", done_cnt - d0, 0);
`else
      repeat (80) tick;
      chk("nowd_run", run, 1);
      chk("nowd_timeout", to_cnt, 0);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("nowd_abort_run", run, 0);
      chk("nowd_no_done", done_cnt - d0, 0);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
